// File: rtl/ps2_rx_fifo_if.sv
// CPU-side register bus of the PS/2 receiver: selects, strobes, write/read data and interrupt.
// The master drives the bus; the receiver is the slave and answers with data_out and irq.
interface ps2_rx_fifo_if;
    logic        status_cs;
    logic        scancode_cs;
    logic        read;
    logic        write;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    modport master (
        output status_cs, scancode_cs, read, write, data_in,
        input  data_out, irq
    );

    modport slave (
        input  status_cs, scancode_cs, read, write, data_in,
        output data_out, irq
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronises and deglitches the PS/2 lines, decodes 11-bit frames and
// queues good bytes in a FIFO with a status register, sticky errors and an interrupt.
module ps2_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_clock,
    input  logic          ps2_data,
    ps2_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, fall, dat_smp;
    logic [FW-1:0] filt_cnt;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tmo_cnt;
    logic          push_req, par_set, frm_set;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          parity_err, overflow, frame_err, scan_rd_prev;
    logic          full, rd_sel, pop, push_ok, flush, clr_wr, overflow_set;
    logic          unused_bits;

    // A new ps2_clock level is accepted only after FILTER_LEN consecutive agreeing samples;
    // the falling edge is registered together with the data sample taken on that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
            dat_smp  <= 1'b1;
        end else begin
            clk_s1  <= ps2_clock;
            clk_s2  <= clk_s1;
            dat_s1  <= ps2_data;
            dat_s2  <= dat_s1;
            dat_smp <= dat_s2;
            fall    <= 1'b0;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= ~clk_s2;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Frame decoder; its outputs are single-cycle request pulses consumed by the FIFO block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            tmo_cnt  <= '0;
            push_req <= 1'b0;
            par_set  <= 1'b0;
            frm_set  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            par_set  <= 1'b0;
            frm_set  <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_smp) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_smp, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok  <= ^{shreg, dat_smp};
                        par_set <= ~(^{shreg, dat_smp});
                        state   <= STOP;
                    end
                    STOP: begin
                        state    <= IDLE;
                        frm_set  <= ~dat_smp;
                        push_req <= dat_smp & par_ok;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state   <= IDLE;
                    frm_set <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign rd_sel       = bus.read & bus.scancode_cs;
    assign pop          = rd_sel & ~scan_rd_prev & (count != '0);
    assign clr_wr       = bus.write & bus.status_cs;
    assign flush        = clr_wr & bus.data_in[24];
    assign push_ok      = push_req & (~full | pop);
    assign overflow_set = push_req & full & ~pop & ~flush;
    assign unused_bits  = ^{bus.data_in[31], bus.data_in[27:25], bus.data_in[23:0]};

    // Set events are ORed in after the write-one-to-clear so a same-cycle set wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            parity_err   <= 1'b0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
            scan_rd_prev <= 1'b0;
        end else begin
            scan_rd_prev <= rd_sel;
            parity_err   <= par_set      | (parity_err & ~(clr_wr & bus.data_in[30]));
            overflow     <= overflow_set | (overflow   & ~(clr_wr & bus.data_in[29]));
            frame_err    <= frm_set      | (frame_err  & ~(clr_wr & bus.data_in[28]));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push_ok) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush) mem[wr_ptr] <= shreg;
    end

    always_comb begin
        bus.data_out = 32'h0;
        if (bus.status_cs) begin
            bus.data_out[31]    = (count != '0);
            bus.data_out[30]    = parity_err;
            bus.data_out[29]    = overflow;
            bus.data_out[28]    = frame_err;
            bus.data_out[23:16] = 8'(count);
        end else if (bus.scancode_cs && count != '0) begin
            bus.data_out[31:24] = mem[rd_ptr];
        end
    end

    assign bus.irq = (count != '0) | parity_err | overflow | frame_err;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table-driven frames, hand-written corner sequences
// and randomized frames checked against a queue-based model of the receiver.
module tb_ps2_rx_fifo;
    localparam int DEPTH      = 4;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 120;
    localparam int HP         = 10;

    typedef struct {
        byte unsigned code;
        bit           bad_par;
        bit           bad_stop;
        logic [31:0]  exp_status;
        logic [31:0]  exp_code;
        logic         exp_irq;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2_clock = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    byte unsigned model_q[$];
    bit m_par, m_ovf, m_frm;
    vec_t vecs[5];

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[31]    = (model_q.size() != 0);
        s[30]    = m_par;
        s[29]    = m_ovf;
        s[28]    = m_frm;
        s[23:16] = 8'(model_q.size());
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One PS/2 bit; optional sub-filter glitch while high, optional pop aligned with the push.
    task automatic ps2_bit(input bit b, input bit glitch, input bit pop, output logic [31:0] popped);
        @(posedge clock); #1 ps2_data = b;
        if (glitch) begin
            repeat (2) @(posedge clock);
            #1 ps2_clock = 1'b0;
            repeat (FILTER_LEN - 1) @(posedge clock);
            #1 ps2_clock = 1'b1;
        end
        repeat (HP) @(posedge clock);
        #1 ps2_clock = 1'b0;
        popped = '0;
        if (pop) begin
            repeat (FILTER_LEN + 3) @(posedge clock);
            #1 bus.scancode_cs = 1'b1; bus.read = 1'b1;
            #1 popped = bus.data_out;
            @(posedge clock);
            #1 bus.scancode_cs = 1'b0; bus.read = 1'b0;
        end
        repeat (HP) @(posedge clock);
        #1 ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input byte unsigned d, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch, input bit pop,
                              output logic [31:0] popped, output logic [31:0] exp_pop);
        logic [10:0] f;
        logic [31:0] p;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        popped  = '0;
        exp_pop = '0;
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(f[i], glitch && (i == 3), pop && (i == 10), p);
            if (i == 10) popped = p;
        end
        if (nbits == 11) begin
            if (pop && model_q.size() != 0) exp_pop = {model_q.pop_front(), 24'h0};
            if (bad_par)  m_par = 1'b1;
            if (bad_stop) m_frm = 1'b1;
            if (!bad_par && !bad_stop) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [31:0] a, b;
        send_frame(v.code, v.bad_par, v.bad_stop, 11, 1'b0, 1'b0, a, b);
    endtask

    task automatic read_status(output logic [31:0] act, output logic irq_act);
        @(negedge clock);
        bus.status_cs = 1'b1; bus.read = 1'b1;
        #1 act = bus.data_out;
        irq_act = bus.irq;
        @(negedge clock);
        bus.status_cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic check_status_model(input string name);
        logic [31:0] act;
        logic        irq_act;
        read_status(act, irq_act);
        check_output(name, act, model_status());
        check_output({name, " irq"}, 32'(irq_act), 32'(model_status() != 0));
    endtask

    task automatic read_code(output logic [31:0] act, output logic [31:0] exp);
        exp = '0;
        if (model_q.size() != 0) exp = {model_q.pop_front(), 24'h0};
        @(negedge clock);
        bus.scancode_cs = 1'b1; bus.read = 1'b1;
        #1 act = bus.data_out;
        @(negedge clock);
        bus.scancode_cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic write_status(input logic [31:0] d);
        @(negedge clock);
        bus.status_cs = 1'b1; bus.write = 1'b1; bus.data_in = d;
        @(negedge clock);
        bus.status_cs = 1'b0; bus.write = 1'b0; bus.data_in = '0;
        if (d[30]) m_par = 1'b0;
        if (d[29]) m_ovf = 1'b0;
        if (d[28]) m_frm = 1'b0;
        if (d[24]) model_q.delete();
    endtask

    initial begin
        logic [31:0] act, exp, pa, pe;
        logic        irq_act;
        byte unsigned rd;
        int          r;

        bus.status_cs = 1'b0; bus.scancode_cs = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.data_in = '0;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 32'h8001_0000, 32'h1C00_0000, 1'b1};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b1};
        vecs[2] = '{8'hA5, 1'b0, 1'b1, 32'h1000_0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{8'hF0, 1'b0, 1'b0, 32'h8001_0000, 32'hF000_0000, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 32'h8001_0000, 32'hFF00_0000, 1'b1};

        repeat (3) @(posedge clock);
        read_status(act, irq_act);
        check_output("reset status", act, 32'h0);
        check_output("reset irq", 32'(irq_act), 32'h0);
        @(negedge clock) reset = 1'b0;
        repeat (5) @(posedge clock);
        read_code(act, exp);
        check_output("empty scancode", act, 32'h0);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            read_status(act, irq_act);
            check_output($sformatf("vec%0d status", i), act, vecs[i].exp_status);
            check_output($sformatf("vec%0d irq", i), 32'(irq_act), 32'(vecs[i].exp_irq));
            read_code(act, exp);
            check_output($sformatf("vec%0d code", i), act, vecs[i].exp_code);
            write_status(32'h7000_0000);
            read_status(act, irq_act);
            check_output($sformatf("vec%0d status after", i), act, 32'h0);
            check_output($sformatf("vec%0d irq after", i), 32'(irq_act), 32'h0);
        end

        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0, 1'b0, pa, pe);
        write_status(32'h4000_0000);
        read_status(act, irq_act);
        check_output("parity clear irq", 32'(irq_act), 32'h0);

        for (int i = 1; i <= DEPTH + 1; i++)
            send_frame(8'(i * 17), 1'b0, 1'b0, 11, 1'b0, 1'b0, pa, pe);
        read_status(act, irq_act);
        check_output("overflow status", act, 32'hA004_0000);
        for (int i = 1; i <= DEPTH; i++) begin
            read_code(act, exp);
            check_output($sformatf("overflow read%0d", i), act, {8'(i * 17), 24'h0});
        end
        write_status(32'h2000_0000);
        read_status(act, irq_act);
        check_output("overflow cleared", act, 32'h0);

        send_frame(8'h3A, 1'b0, 1'b0, 6, 1'b0, 1'b0, pa, pe);
        repeat (TIMEOUT + 40) @(posedge clock);
        m_frm = 1'b1;
        read_status(act, irq_act);
        check_output("timeout status", act, 32'h1000_0000);
        write_status(32'h1000_0000);
        send_frame(8'h3A, 1'b0, 1'b0, 11, 1'b0, 1'b0, pa, pe);
        read_code(act, exp);
        check_output("after timeout code", act, 32'h3A00_0000);

        send_frame(8'h61, 1'b0, 1'b0, 11, 1'b0, 1'b0, pa, pe);
        send_frame(8'h62, 1'b0, 1'b0, 11, 1'b0, 1'b0, pa, pe);
        @(negedge clock);
        bus.scancode_cs = 1'b1; bus.read = 1'b1;
        repeat (3) @(negedge clock);
        bus.scancode_cs = 1'b0; bus.read = 1'b0;
        void'(model_q.pop_front());
        read_status(act, irq_act);
        check_output("held read status", act, 32'h8001_0000);
        read_code(act, exp);
        check_output("held read next", act, 32'h6200_0000);

        for (int i = 1; i <= DEPTH; i++)
            send_frame(8'(8'h70 + i), 1'b0, 1'b0, 11, 1'b0, 1'b0, pa, pe);
        send_frame(8'h75, 1'b0, 1'b0, 11, 1'b0, 1'b1, pa, pe);
        check_output("push+pop popped", pa, 32'h7100_0000);
        read_status(act, irq_act);
        check_output("push+pop status", act, 32'h8004_0000);
        for (int i = 2; i <= DEPTH + 1; i++) begin
            read_code(act, exp);
            check_output($sformatf("push+pop read%0d", i), act, {8'(8'h70 + i), 24'h0});
        end

        ps2_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1 ps2_clock = 1'b0;
            repeat (FILTER_LEN - 1) @(posedge clock);
            #1 ps2_clock = 1'b1;
            repeat (HP) @(posedge clock);
        end
        ps2_data = 1'b1;
        repeat (HP) @(posedge clock);
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1, 1'b0, pa, pe);
        read_status(act, irq_act);
        check_output("glitch status", act, 32'h8001_0000);
        read_code(act, exp);
        check_output("glitch code", act, 32'h5A00_0000);

        send_frame(8'h29, 1'b0, 1'b0, 4, 1'b0, 1'b0, pa, pe);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        model_q.delete();
        m_par = 1'b0; m_ovf = 1'b0; m_frm = 1'b0;
        repeat (TIMEOUT + 40) @(posedge clock);
        read_status(act, irq_act);
        check_output("reset mid-frame status", act, 32'h0);
        send_frame(8'h29, 1'b0, 1'b0, 11, 1'b0, 1'b0, pa, pe);
        read_code(act, exp);
        check_output("reset mid-frame code", act, 32'h2900_0000);

        for (int i = 0; i < 14; i++) begin
            rd = 8'($urandom);
            r  = int'($urandom_range(0, 7));
            send_frame(rd, r == 0, r == 1, 11, 1'b0, 1'b0, pa, pe);
            if ($urandom_range(0, 1) == 1) begin
                read_code(act, exp);
                check_output($sformatf("rand%0d code", i), act, exp);
            end
            check_status_model($sformatf("rand%0d status", i));
            if ($urandom_range(0, 3) == 0) begin
                write_status({1'b0, 3'($urandom), 3'b0, 1'($urandom_range(0, 3) == 0), 24'h0});
                check_status_model($sformatf("rand%0d after write", i));
            end
        end
        while (model_q.size() != 0) begin
            read_code(act, exp);
            check_output("drain code", act, exp);
        end
        check_status_model("final status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter FILTER_LEN, default 4, consecutive equal samples needed to accept a ps2_clock level change.
REQ-003 SHALL have parameter TIMEOUT, default 4096, clock cycles without a falling edge before an open frame is abandoned.
REQ-004 SHALL have port: clock  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: ps2_clock, ps2_data  input  1 each  raw, unsynchronised PS/2 lines.
REQ-007 SHALL have ports: status_cs, scancode_cs  input  1 each  register selects from the board address decoder.
REQ-008 SHALL have ports: read, write  input  1 each  CPU bus strobes.
REQ-009 SHALL have port: data_in  input  32  CPU write data.
REQ-010 SHALL have port: data_out  output  32  read data; 32'h0 when neither cs is asserted.
REQ-011 SHALL have port: irq  output  1  high while the FIFO is not empty or any sticky error is set.

Function
REQ-012 SHALL pass ps2_clock and ps2_data through two-flop synchronisers before any use.
REQ-013 SHALL change the filtered ps2_clock level only after FILTER_LEN consecutive synchronised samples at the new level.
REQ-014 SHALL generate a one-cycle edge pulse on each filtered 1->0 transition; ps2_data is sampled on that cycle.
REQ-015 SHALL run a frame FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing one state or bit per edge pulse.
REQ-016 SHALL leave IDLE only when the sampled start bit is 0; a start bit of 1 is ignored and the FSM stays in IDLE.
REQ-017 SHALL check odd parity over the 8 data bits plus the parity bit; a mismatch sets sticky parity_err and the byte is discarded.
REQ-018 SHALL treat a stop bit of 0 as a framing error: set sticky frame_err and discard the byte.
REQ-019 SHALL return to IDLE from any non-IDLE state after TIMEOUT cycles with no edge pulse, set frame_err, and discard the partial byte.
REQ-020 SHALL push a byte that passes parity and stop checks into the FIFO on the STOP-state edge pulse.
REQ-021 SHALL, on a push while the FIFO is full and no pop occurs that cycle, drop the byte and set sticky overflow; FIFO contents are unchanged.
REQ-022 SHALL pop exactly once per read access: on the first cycle that read & scancode_cs is high after being low the previous cycle.
REQ-023 SHALL return {head_byte, 24'h0} on data_out while scancode_cs is high; when empty, 32'h0 with no pointer change.
REQ-024 SHALL apply a simultaneous push and pop together; count is unchanged; when full, the push succeeds and overflow is not set.
REQ-025 SHALL return status on data_out while status_cs is high: bit31 not_empty, bit30 parity_err, bit29 overflow, bit28 frame_err, bits[23:16] count, all other bits 0.
REQ-026 SHALL, on write & status_cs, clear each sticky bit whose data_in bit (30/29/28) is 1 (write-one-to-clear).
REQ-027 SHALL, on write & status_cs with data_in[24]=1, flush the FIFO (pointers and count to 0) on that edge; a same-cycle push is lost.
REQ-028 SHALL give a set event priority over a same-cycle clear of the same sticky bit.
REQ-029 SHALL use wrapping read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits, with count zero-extended into bits[23:16].
REQ-030 SHALL ignore write & scancode_cs and read & status_cs side effects (status reads do not clear anything).

Reset
REQ-031 SHALL, while reset is high, force FSM to IDLE, pointers, count, sticky bits, filter and timeout counters to 0, filtered ps2_clock to 1, and irq to 0.
REQ-032 SHALL discard a frame in progress when reset is asserted; the FSM resumes only on a new start bit after release.

Verification
REQ-033 SHALL cover: frame 0x1C, correct parity -> status = 0x8001_0000, scancode read = 0x1C00_0000, then status = 0x0.
REQ-034 SHALL cover: frame 0x1C, wrong parity -> status bit30 set, count 0, irq 1; write 0x4000_0000 to status -> irq 0.
REQ-035 SHALL cover: DEPTH+1 frames with no reads -> count = DEPTH, overflow set, reads return first DEPTH bytes in order.
REQ-036 SHALL cover: 5 data bits then bus idle for TIMEOUT cycles -> frame_err set, FSM IDLE, next full frame received correctly.
REQ-037 SHALL cover: read held high for 3 cycles on scancode_cs -> exactly one pop; push coinciding with pop on a full FIFO -> count stays DEPTH, no overflow.
REQ-038 SHALL cover: 1-cycle glitches on ps2_clock shorter than FILTER_LEN -> no edge pulse, no bit shifted.
